// File: rtl/fifo_cdc_pkg.sv
// Shared types and helpers for the async-FIFO pointer-domain blocks.
package fifo_cdc_pkg;

  typedef enum logic {WR_SIDE, RD_SIDE} side_e;

  localparam int MIN_SYNC_STAGES = 2;

  // One extra pointer bit beyond the RAM address distinguishes full from empty.
  function automatic int ptr_width(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/bin2gray.sv
// Binary to reflected Gray code conversion, purely combinational.
module bin2gray #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray2bin.sv
// Reflected Gray code to binary conversion, purely combinational.
module gray2bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign bin[gi] = ^gray[WIDTH-1:gi];
    end
  endgenerate

endmodule

// File: rtl/gray_sync_chain.sv
// Plain multi-flop synchroniser for a Gray-coded (single-bit-change) bus.
module gray_sync_chain
  import fifo_cdc_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  localparam int NST = (STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : STAGES;

  logic [NST-1:0][WIDTH-1:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[NST-2:0], d};
    end
  end

  assign q = sync_reg[NST-1];

endmodule

// File: rtl/fifo_gray_ptr_ctrl.sv
// One clock-domain side of an async FIFO: local binary/Gray pointer, synchronised
// remote pointer, registered full (write side) or empty (read side) flag, occupancy.
module fifo_gray_ptr_ctrl
  import fifo_cdc_pkg::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int IS_WRITE    = 1,
  localparam int PW         = ptr_width(ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc,
  input  logic [PW-1:0]         remote_gray,
  output logic                  accept,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [PW-1:0]         ptr_gray,
  output logic                  flag,
  output logic [PW-1:0]         level
);

  localparam side_e SIDE = (IS_WRITE != 0) ? WR_SIDE : RD_SIDE;

  logic [PW-1:0] ptr_bin_reg;
  logic [PW-1:0] ptr_gray_reg;
  logic          flag_reg;
  logic [PW-1:0] bin_next;
  logic [PW-1:0] gray_next;
  logic [PW-1:0] rsync;
  logic [PW-1:0] rsync_bin;
  logic [PW-1:0] full_cmp;
  logic          flag_next;

  assign accept   = inc & ~flag_reg;
  assign bin_next = ptr_bin_reg + {{(PW-1){1'b0}}, accept};

  bin2gray #(.WIDTH(PW)) u_bin2gray (
    .bin  (bin_next),
    .gray (gray_next)
  );

  gray_sync_chain #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (remote_gray),
    .q     (rsync)
  );

  gray2bin #(.WIDTH(PW)) u_gray2bin (
    .gray (rsync),
    .bin  (rsync_bin)
  );

  // Full when the write pointer is one lap ahead: top two Gray bits inverted.
  assign full_cmp  = {~rsync[PW-1:PW-2], rsync[PW-3:0]};
  assign flag_next = (SIDE == WR_SIDE) ? (gray_next == full_cmp) : (gray_next == rsync);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_bin_reg  <= '0;
      ptr_gray_reg <= '0;
      flag_reg     <= (SIDE == RD_SIDE);
    end else begin
      ptr_bin_reg  <= bin_next;
      ptr_gray_reg <= gray_next;
      flag_reg     <= flag_next;
    end
  end

  assign addr     = ptr_bin_reg[ADDR_WIDTH-1:0];
  assign ptr_gray = ptr_gray_reg;
  assign flag     = flag_reg;
  assign level    = (SIDE == WR_SIDE) ? (ptr_bin_reg - rsync_bin) : (rsync_bin - ptr_bin_reg);

endmodule

// File: tb/tb_fifo_gray_ptr_ctrl.sv
// Directed bench: a write-side and a read-side instance (depth 4), optionally looped back.
module tb_fifo_gray_ptr_ctrl;

  logic       clk;
  logic       rst_n;
  logic       loop;
  logic       inc_wr, inc_rd;
  logic [2:0] rg_wr, rg_rd;
  logic [2:0] wr_remote, rd_remote;
  logic       wr_accept, rd_accept;
  logic [1:0] wr_addr, rd_addr;
  logic [2:0] wr_gray, rd_gray;
  logic       wr_flag, rd_flag;
  logic [2:0] wr_level, rd_level;

  int n_checks = 0;
  int n_fail   = 0;

  assign wr_remote = loop ? rd_gray : rg_wr;
  assign rd_remote = loop ? wr_gray : rg_rd;

  fifo_gray_ptr_ctrl #(.ADDR_WIDTH(2), .SYNC_STAGES(2), .IS_WRITE(1)) u_wr (
    .clk(clk), .rst_n(rst_n), .inc(inc_wr), .remote_gray(wr_remote),
    .accept(wr_accept), .addr(wr_addr), .ptr_gray(wr_gray), .flag(wr_flag), .level(wr_level)
  );

  fifo_gray_ptr_ctrl #(.ADDR_WIDTH(2), .SYNC_STAGES(2), .IS_WRITE(0)) u_rd (
    .clk(clk), .rst_n(rst_n), .inc(inc_rd), .remote_gray(rd_remote),
    .accept(rd_accept), .addr(rd_addr), .ptr_gray(rd_gray), .flag(rd_flag), .level(rd_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [2:0] to_gray(input int b);
    logic [2:0] x;
    x = b[2:0];
    return x ^ (x >> 1);
  endfunction

  typedef struct {
    logic       side;   // 0 = write instance, 1 = read instance
    logic       inc;
    logic [2:0] rg;
    logic       acc;
    logic [2:0] gray;
    logic       flag;
    logic [2:0] level;
    logic [1:0] addr;
  } vec_t;

  localparam int NV = 16;
  vec_t vec [NV];

  int wc, rc, got;

  initial begin
    // Write side: fill with remote at 000, then release one slot remotely.
    vec[0]  = '{1'b0, 1'b1, 3'b000, 1'b1, 3'b001, 1'b0, 3'd1, 2'd1};
    vec[1]  = '{1'b0, 1'b1, 3'b000, 1'b1, 3'b011, 1'b0, 3'd2, 2'd2};
    vec[2]  = '{1'b0, 1'b1, 3'b000, 1'b1, 3'b010, 1'b0, 3'd3, 2'd3};
    vec[3]  = '{1'b0, 1'b1, 3'b000, 1'b1, 3'b110, 1'b1, 3'd4, 2'd0};
    vec[4]  = '{1'b0, 1'b1, 3'b000, 1'b0, 3'b110, 1'b1, 3'd4, 2'd0};
    vec[5]  = '{1'b0, 1'b0, 3'b001, 1'b0, 3'b110, 1'b1, 3'd4, 2'd0};
    vec[6]  = '{1'b0, 1'b0, 3'b001, 1'b0, 3'b110, 1'b1, 3'd3, 2'd0};
    vec[7]  = '{1'b0, 1'b0, 3'b001, 1'b0, 3'b110, 1'b0, 3'd3, 2'd0};
    vec[8]  = '{1'b0, 1'b1, 3'b001, 1'b1, 3'b111, 1'b1, 3'd4, 2'd1};
    // Read side: remote jumps to bin 3, then drain to empty.
    vec[9]  = '{1'b1, 1'b0, 3'b010, 1'b0, 3'b000, 1'b1, 3'd0, 2'd0};
    vec[10] = '{1'b1, 1'b0, 3'b010, 1'b0, 3'b000, 1'b1, 3'd3, 2'd0};
    vec[11] = '{1'b1, 1'b0, 3'b010, 1'b0, 3'b000, 1'b0, 3'd3, 2'd0};
    vec[12] = '{1'b1, 1'b1, 3'b010, 1'b1, 3'b001, 1'b0, 3'd2, 2'd1};
    vec[13] = '{1'b1, 1'b1, 3'b010, 1'b1, 3'b011, 1'b0, 3'd1, 2'd2};
    vec[14] = '{1'b1, 1'b1, 3'b010, 1'b1, 3'b010, 1'b1, 3'd0, 2'd3};
    vec[15] = '{1'b1, 1'b1, 3'b010, 1'b0, 3'b010, 1'b1, 3'd0, 2'd3};

    rst_n = 1'b1; loop = 1'b0;
    inc_wr = 1'b0; inc_rd = 1'b0; rg_wr = 3'b000; rg_rd = 3'b000;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_gray",  wr_gray,  0);
    chk("rst_wr_addr",  wr_addr,  0);
    chk("rst_wr_level", wr_level, 0);
    chk("rst_wr_flag",  wr_flag,  0);
    chk("rst_rd_gray",  rd_gray,  0);
    chk("rst_rd_level", rd_level, 0);
    chk("rst_rd_flag",  rd_flag,  1);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      if (vec[i].side == 1'b0) begin
        inc_wr = vec[i].inc; rg_wr = vec[i].rg; inc_rd = 1'b0;
      end else begin
        inc_rd = vec[i].inc; rg_rd = vec[i].rg; inc_wr = 1'b0;
      end
      #1;
      chk($sformatf("vec%0d_accept", i), vec[i].side ? rd_accept : wr_accept, vec[i].acc);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_gray", i),  vec[i].side ? rd_gray  : wr_gray,  vec[i].gray);
      chk($sformatf("vec%0d_flag", i),  vec[i].side ? rd_flag  : wr_flag,  vec[i].flag);
      chk($sformatf("vec%0d_level", i), vec[i].side ? rd_level : wr_level, vec[i].level);
      chk($sformatf("vec%0d_addr", i),  vec[i].side ? rd_addr  : wr_addr,  vec[i].addr);
      $display("vec %0d side=%0d inc=%0d rg=%b -> gray=%b flag=%0d level=%0d",
               i, vec[i].side, vec[i].inc, vec[i].rg,
               vec[i].side ? rd_gray : wr_gray, vec[i].side ? rd_flag : wr_flag,
               vec[i].side ? rd_level : wr_level);
    end
    inc_wr = 1'b0; inc_rd = 1'b0;

    // Looped-back push/pop pairs running both pointers through wrap-around.
    rst_n = 1'b0; rg_wr = 3'b000; rg_rd = 3'b000; loop = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    wc = 0; rc = 0;
    for (int p = 0; p < 12; p++) begin
      inc_wr = 1'b1;
      #1 chk($sformatf("wrap%0d_wr_accept", p), wr_accept, 1);
      @(posedge clk); #1;
      inc_wr = 1'b0; wc++;
      chk($sformatf("wrap%0d_wr_gray", p), wr_gray, to_gray(wc));
      chk($sformatf("wrap%0d_wr_addr", p), wr_addr, wc % 4);
      chk($sformatf("wrap%0d_wr_flag", p), wr_flag, 0);
      got = 0;
      for (int k = 0; k < 10 && got == 0; k++) begin
        chk($sformatf("wrap%0d_levels_ok", p), (wr_level <= 3'd4) && (rd_level <= 3'd4), 1);
        if (rd_flag == 1'b0) got = 1;
        else begin @(posedge clk); #1; end
      end
      chk($sformatf("wrap%0d_rd_ready", p), got, 1);
      inc_rd = 1'b1;
      #1 chk($sformatf("wrap%0d_rd_accept", p), rd_accept, 1);
      @(posedge clk); #1;
      inc_rd = 1'b0; rc++;
      chk($sformatf("wrap%0d_rd_gray", p), rd_gray, to_gray(rc));
      chk($sformatf("wrap%0d_rd_addr", p), rd_addr, rc % 4);
      $display("pair %0d wr_gray=%b rd_gray=%b wr_addr=%0d rd_addr=%0d",
               p, wr_gray, rd_gray, wr_addr, rd_addr);
    end

    // Fill the write side to full with a nonzero synchronised remote, then reset asynchronously.
    rg_wr = 3'b110; rg_rd = 3'b110; loop = 1'b0;
    for (int j = 0; j < 4; j++) begin
      inc_wr = 1'b1;
      #1 chk($sformatf("fill%0d_accept", j), wr_accept, 1);
      @(posedge clk); #1;
      wc++;
    end
    inc_wr = 1'b0;
    chk("full_gray", wr_gray, 0);
    chk("full_flag", wr_flag, 1);
    chk("full_level", wr_level, 4);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wr_gray",  wr_gray,  0);
    chk("arst_wr_addr",  wr_addr,  0);
    chk("arst_wr_level", wr_level, 0);
    chk("arst_wr_flag",  wr_flag,  0);
    chk("arst_rd_gray",  rd_gray,  0);
    chk("arst_rd_flag",  rd_flag,  1);
    $display("async reset: wr_gray=%b wr_flag=%0d rd_flag=%0d", wr_gray, wr_flag, rd_flag);
    rg_wr = 3'b000; rg_rd = 3'b000;
    @(posedge clk); #1;
    rst_n = 1'b1;
    inc_wr = 1'b1;
    #1 chk("resume_accept", wr_accept, 1);
    @(posedge clk); #1;
    inc_wr = 1'b0;
    chk("resume_gray", wr_gray, 3'b001);
    chk("resume_level", wr_level, 1);
    chk("resume_flag", wr_flag, 0);
    $display("resume: wr_gray=%b level=%0d", wr_gray, wr_level);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_gray_ptr_ctrl.md
Name: fifo_gray_ptr_ctrl

Overview:
One side of an async-FIFO pointer domain. It keeps the local binary and Gray pointers and synchronises the remote Gray pointer into the local clock. From these it produces the registered full flag (write side) or empty flag (read side) and an occupancy level. One instance per clock domain; the two instances exchange only registered Gray pointers.

Parameters:
ADDR_WIDTH, 4, RAM address bits; depth = 2**ADDR_WIDTH; must be >= 2; pointer width PW = ADDR_WIDTH+1.
SYNC_STAGES, 2, flops in the remote-pointer synchroniser; must be >= 2.
IS_WRITE, 1, 1 = write side (flag means full); 0 = read side (flag means empty).

Ports:
clk  in  1  local domain clock
rst_n  in  1  asynchronous active-low reset
inc  in  1  push request (write side) or pop request (read side)
remote_gray  in  PW  Gray pointer from the other domain; asynchronous to clk
accept  out  1  inc & ~flag; the operation takes place this cycle
addr  out  ADDR_WIDTH  RAM address = ptr_bin[ADDR_WIDTH-1:0]
ptr_gray  out  PW  registered local Gray pointer, sent to the other domain
flag  out  1  full (IS_WRITE=1) or empty (IS_WRITE=0), registered
level  out  PW  occupancy seen from this side, 0..2**ADDR_WIDTH

Behaviour:
- Reset (async assert, sync release by the system):
  - ptr_bin, ptr_gray and all sync flops = 0; level = 0; addr = 0.
  - flag = 0 when IS_WRITE=1, flag = 1 when IS_WRITE=0.
- accept is combinational. inc while flag=1 is ignored; no state changes.
- Pointer update:
  - bin_next = ptr_bin + accept, modulo 2**PW.
  - gray_next = bin2gray(bin_next).
  - Both registered on the clk edge, so ptr_gray is glitch-free and changes by at most one bit per cycle.
- Synchroniser: remote_gray passes through SYNC_STAGES flops to give rsync. rsync_bin = gray2bin(rsync), combinational.
- Write side: flag <= (gray_next == {~rsync[PW-1:PW-2], rsync[PW-3:0]}).
- Read side: flag <= (gray_next == rsync).
- The flag is computed from gray_next, so it asserts in the same edge as the accept that fills or empties the FIFO. Back-to-back inc never overruns or underruns.
- level, combinational from registered state, modulo 2**PW:
  - write side: ptr_bin - rsync_bin.
  - read side: rsync_bin - ptr_bin.
  - Conservative: it lags remote activity.
- Remote pointer latency: a remote change is visible in rsync after SYNC_STAGES edges, and in flag one edge later (3 cycles for the default).
- Wrap-around: ptr_bin wraps 2**PW-1 -> 0 with no special case. The MSB distinguishes full from empty.
- Simultaneous local accept and remote change: the flag uses the new gray_next against the current rsync. The newer remote value is picked up on later cycles, so the flag is never optimistic.
- Reset mid-operation: all registers go to reset values immediately, without a clock edge. An in-flight inc is discarded.

Decomposition:
- Package fifo_cdc_pkg holds:
  - typedef enum side_e {WR_SIDE, RD_SIDE};
  - function ptr_width(addr_w) returning addr_w+1;
  - localparam MIN_SYNC_STAGES = 2.
- Sub-module gray_sync_chain (WIDTH, STAGES): a plain multi-flop synchroniser, reused by the reset and handshake CDC blocks.
- Code conversion reuses the existing bin2gray and gray2bin library modules. No local re-implementation.

Test Plan:
All scenarios use ADDR_WIDTH=2 (depth 4, PW=3) and SYNC_STAGES=2.
- Reset: hold rst_n=0 -> ptr_gray=000, addr=0, level=0; flag=0 on WR, flag=1 on RD.
- WR fill, remote_gray=000: inc for 5 cycles -> ptr_gray goes 001,011,010,110; flag=1 after the 4th edge; 5th inc gives accept=0 and ptr_gray stays 110; level=4.
- WR drain release: from full, remote_gray steps 000->001 -> flag falls exactly 3 edges later; level goes 4->3 after 2 edges; next inc accepted, ptr_gray=111.
- RD empty: remote_gray set to 010 (bin 3) -> flag=0 and level=3 after 3 edges; inc for 3 cycles -> flag=1 on the 3rd accept edge; ptr_gray=010; 4th inc ignored.
- Wrap: WR and RD instances looped back, 12 push/pop pairs -> ptr_bin wraps 111->000 (Gray 100->000), addr 3->0; no spurious full/empty; level never exceeds 4.
- Async reset mid-run: with flag=1 (WR) and rsync nonzero, drop rst_n between clk edges -> all outputs take reset values before the next edge; normal operation resumes after release.
